// File: rtl/vga_sync_gen.sv
// VGA 640x480 timing generator.
// A clock divider produces a one-clk pixel strobe. The pixel and line counters
// advance on that strobe. Sync and visible-area flags are decoded directly from
// the counters. A frame strobe and a frame counter mark each completed frame.
// The geometry parameters default to standard 640x480@60 timing.
`timescale 1ns/1ps

module vga_sync_gen #(
  parameter int PIX_DIV     = 4,    // clk cycles per pixel, 2..16
  parameter int FCNT_W      = 16,   // width of frame_count
  parameter int H_TOTAL     = 800,  // pixels per line
  parameter int H_SYNC      = 96,   // hSync low for hCount < H_SYNC
  parameter int H_ACT_START = 144,  // first visible pixel
  parameter int H_ACT       = 640,  // visible pixels per line
  parameter int V_TOTAL     = 525,  // lines per frame
  parameter int V_SYNC      = 2,    // vSync low for vCount < V_SYNC
  parameter int V_ACT_START = 35,   // first visible line
  parameter int V_ACT       = 480   // visible lines per frame
) (
  input  logic              clk,
  input  logic              rst,
  output logic [9:0]        hCount,
  output logic [9:0]        vCount,
  output logic              hSync,
  output logic              vSync,
  output logic              bright,
  output logic              pix_en,
  output logic              frame_tick,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_SYNC_C  = 10'(H_SYNC);
  localparam logic [9:0]       V_SYNC_C  = 10'(V_SYNC);
  localparam logic [9:0]       H_ACT_LO  = 10'(H_ACT_START);
  localparam logic [9:0]       H_ACT_HI  = 10'(H_ACT_START + H_ACT - 1);
  localparam logic [9:0]       V_ACT_LO  = 10'(V_ACT_START);
  localparam logic [9:0]       V_ACT_HI  = 10'(V_ACT_START + V_ACT - 1);

  logic [DIV_W-1:0]  r_div;
  logic              r_pix_en;
  logic [9:0]        r_h;
  logic [9:0]        r_v;
  logic              r_frame_tick;
  logic [FCNT_W-1:0] r_frame_count;

  logic w_div_last;
  logic w_h_last;
  logic w_v_last;

  assign w_div_last = (r_div == DIV_LAST);
  assign w_h_last   = (r_h == H_LAST);
  assign w_v_last   = (r_v == V_LAST);

  // Pixel-rate divider. The strobe is registered, so it is high in the cycle after the divider holds its last value.
  always_ff @(posedge clk) begin
    // NOTE: every state register is updated with <= so that all flops sample
    // pre-edge values. Blocking assignments here would chain the updates and
    // skew the pixel strobe against the counters it gates.
    if (rst) begin
      r_div    <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_pix_en <= w_div_last;
      r_div    <= w_div_last ? '0 : r_div + DIV_W'(1);
    end
  end

  // Horizontal and vertical position counters. They advance only on the pixel strobe.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and is evaluated before the strobe. An edge
    // with rst high therefore discards any pixel step that was due on that edge.
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_pix_en) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  // Frame strobe and frame counter. Both update on the edge that wraps the raster back to (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_tick  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_tick <= r_pix_en && w_h_last && w_v_last;
      if (r_pix_en && w_h_last && w_v_last) begin
        r_frame_count <= r_frame_count + FCNT_W'(1);
      end
    end
  end

  // Sync and visible-area flags are decoded from the counter registers with zero latency.
  assign hSync  = (r_h >= H_SYNC_C);
  assign vSync  = (r_v >= V_SYNC_C);
  assign bright = (r_h >= H_ACT_LO) && (r_h <= H_ACT_HI) &&
                  (r_v >= V_ACT_LO) && (r_v <= V_ACT_HI);

  assign hCount      = r_h;
  assign vCount      = r_v;
  assign pix_en      = r_pix_en;
  assign frame_tick  = r_frame_tick;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen.
// dut_a uses the standard 800x525 raster with PIX_DIV=2, which keeps line-level
// boundaries within reach. dut_b uses PIX_DIV=4, FCNT_W=2 and a small raster,
// so that several whole frames, a frame_count wrap and a mid-frame reset can
// be exercised.
// The expected state after n non-reset edges is derived arithmetically from n.
`timescale 1ns/1ps

module tb_vga_sync_gen;

  // Small raster used by dut_b.
  localparam int B_HT = 20, B_HS = 3, B_HA0 = 5, B_HA = 10;
  localparam int B_VT = 6,  B_VS = 1, B_VA0 = 2, B_VA = 3;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit br;
    bit pe;
    bit ft;
    int fc;
  } obs_t;

  typedef struct {
    longint n;
    obs_t   e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [9:0] hCount_a, vCount_a, hCount_b, vCount_b;
  logic       hSync_a, vSync_a, bright_a, pix_en_a, frame_tick_a;
  logic       hSync_b, vSync_b, bright_b, pix_en_b, frame_tick_b;
  logic [15:0] frame_count_a;
  logic [1:0]  frame_count_b;

  vga_sync_gen #(.PIX_DIV(2)) dut_a (
    .clk(clk), .rst(rst_a), .hCount(hCount_a), .vCount(vCount_a),
    .hSync(hSync_a), .vSync(vSync_a), .bright(bright_a), .pix_en(pix_en_a),
    .frame_tick(frame_tick_a), .frame_count(frame_count_a)
  );

  vga_sync_gen #(
    .PIX_DIV(4), .FCNT_W(2),
    .H_TOTAL(B_HT), .H_SYNC(B_HS), .H_ACT_START(B_HA0), .H_ACT(B_HA),
    .V_TOTAL(B_VT), .V_SYNC(B_VS), .V_ACT_START(B_VA0), .V_ACT(B_VA)
  ) dut_b (
    .clk(clk), .rst(rst_b), .hCount(hCount_b), .vCount(vCount_b),
    .hSync(hSync_b), .vSync(vSync_b), .bright(bright_b), .pix_en(pix_en_b),
    .frame_tick(frame_tick_b), .frame_count(frame_count_b)
  );

  int checks = 0;
  int failures = 0;

  // Expected state after n non-reset clk edges (n=0 means reset was sampled on the last edge).
  function automatic obs_t model(longint n, int d, int ht, int hs, int ha0, int ha,
                                 int vt, int vs, int va0, int va, int fw);
    obs_t   o;
    longint p;
    p    = (n == 0) ? 0 : (n - 1) / d;   // number of pixel steps taken so far
    o.h  = int'(p % ht);
    o.v  = int'((p / ht) % vt);
    o.fc = int'((p / (ht * vt)) % (64'd1 << fw));
    o.pe = (n >= d) && (n % d == 0);
    o.ft = (n > d) && ((n - 1) % d == 0) && (p % (ht * vt) == 0);
    o.hs = (o.h >= hs);
    o.vs = (o.v >= vs);
    o.br = (o.h >= ha0) && (o.h < ha0 + ha) && (o.v >= va0) && (o.v < va0 + va);
    return o;
  endfunction

  function automatic obs_t model_a(longint n);
    return model(n, 2, 800, 96, 144, 640, 525, 2, 35, 480, 16);
  endfunction

  function automatic obs_t model_b(longint n);
    return model(n, 4, B_HT, B_HS, B_HA0, B_HA, B_VT, B_VS, B_VA0, B_VA, 2);
  endfunction

  function automatic obs_t obs_a();
    obs_t o;
    o.h = int'(hCount_a); o.v = int'(vCount_a); o.hs = hSync_a; o.vs = vSync_a;
    o.br = bright_a; o.pe = pix_en_a; o.ft = frame_tick_a; o.fc = int'(frame_count_a);
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.h = int'(hCount_b); o.v = int'(vCount_b); o.hs = hSync_b; o.vs = vSync_b;
    o.br = bright_b; o.pe = pix_en_b; o.ft = frame_tick_b; o.fc = int'(frame_count_b);
    return o;
  endfunction

  function automatic obs_t mk(int h, int v, bit hs, bit vs, bit br, bit pe);
    obs_t o;
    o.h = h; o.v = v; o.hs = hs; o.vs = vs; o.br = br; o.pe = pe; o.ft = 1'b0; o.fc = 0;
    return o;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    checks++;
    if (act.h != exp.h || act.v != exp.v || act.hs != exp.hs || act.vs != exp.vs ||
        act.br != exp.br || act.pe != exp.pe || act.ft != exp.ft || act.fc != exp.fc) begin
      failures++;
      $display("FAIL %s: got h=%0d v=%0d hs=%0b vs=%0b br=%0b pe=%0b ft=%0b fc=%0d ; expected h=%0d v=%0d hs=%0b vs=%0b br=%0b pe=%0b ft=%0b fc=%0d",
               name, act.h, act.v, act.hs, act.vs, act.br, act.pe, act.ft, act.fc,
               exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.pe, exp.ft, exp.fc);
    end
  endtask

  task automatic check_int(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: each edge pushes the expected state. The opposite edge pops it and compares it with the DUT.
  longint n_a = 0, n_b = 0;
  obs_t   q_a[$], q_b[$];

  always @(posedge clk) begin
    n_a = rst_a ? 0 : n_a + 1;
    n_b = rst_b ? 0 : n_b + 1;
    q_a.push_back(model_a(n_a));
    q_b.push_back(model_b(n_b));
  end

  // Line-level counters for dut_a, counted on lines 1 and 35.
  int hs_low_l1 = 0, cyc_l1 = 0, pe_l1 = 0, br_l35 = 0;

  always @(negedge clk) begin
    obs_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("sb_a", obs_a(), e);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("sb_b", obs_b(), e);
    end
    if (!rst_a && vCount_a == 10'd1) begin
      cyc_l1++;
      if (!hSync_a) hs_low_l1++;
      if (pix_en_a) pe_l1++;
    end
    if (!rst_a && vCount_a == 10'd35 && bright_a) br_l35++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [13:1] pat;
    longint      tick_at[4];
    int          fc_seq[4];
    int          ticks, cyc, br_f, vs_f;
    bit          found;

    // dut_a points along the first frame: reset, first pixel strobe, hSync, line wrap, vSync and visible-area edges.
    tbl.push_back('{0,     mk(0,   0,  0, 0, 0, 0)});
    tbl.push_back('{1,     mk(0,   0,  0, 0, 0, 0)});
    tbl.push_back('{2,     mk(0,   0,  0, 0, 0, 1)});
    tbl.push_back('{3,     mk(1,   0,  0, 0, 0, 0)});
    tbl.push_back('{191,   mk(95,  0,  0, 0, 0, 0)});
    tbl.push_back('{193,   mk(96,  0,  1, 0, 0, 0)});
    tbl.push_back('{1599,  mk(799, 0,  1, 0, 0, 0)});
    tbl.push_back('{1600,  mk(799, 0,  1, 0, 0, 1)});
    tbl.push_back('{1601,  mk(0,   1,  0, 0, 0, 0)});
    tbl.push_back('{3199,  mk(799, 1,  1, 0, 0, 0)});
    tbl.push_back('{3201,  mk(0,   2,  0, 1, 0, 0)});
    tbl.push_back('{54801, mk(200, 34, 1, 1, 0, 0)});
    tbl.push_back('{56287, mk(143, 35, 1, 1, 0, 0)});
    tbl.push_back('{56289, mk(144, 35, 1, 1, 1, 0)});
    tbl.push_back('{57567, mk(783, 35, 1, 1, 1, 0)});
    tbl.push_back('{57569, mk(784, 35, 1, 1, 0, 0)});

    repeat (3) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      while (n_a < tbl[i].n) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("vec_a[%0d] n=%0d", i, tbl[i].n), obs_a(), tbl[i].e);
      if (i == 0) rst_a = 1'b0;
    end

    // Finish line 35, then check the per-line totals.
    while (n_a < 57602) begin
      @(posedge clk);
      #1;
    end
    check_int("line_period_clk", cyc_l1, 1600);
    check_int("line_pix_en_count", pe_l1, 800);
    check_int("hsync_low_clk", hs_low_l1, 192);
    check_int("bright_clk_line35", br_l35, 1280);
    rst_a = 1'b1;

    // dut_b leaves reset. The pixel strobe must appear in cycles 4, 8 and 12, and hCount must be 1 after cycle 4.
    rst_b = 1'b0;
    pat = '0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      pat[k] = pix_en_b;
      if (k == 5) check_int("hcount_after_first_pix", hCount_b, 1);
    end
    check_int("pix_en_pattern", pat, 13'h888);

    // Four frames: record each frame_tick, and count bright and vSync-low cycles over the second frame.
    ticks = 0; cyc = 0; br_f = 0; vs_f = 0;
    while (ticks < 4 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (frame_tick_b) begin
        check_int("tick_at_origin", {hCount_b, vCount_b}, 0);
        fc_seq[ticks]  = int'(frame_count_b);
        tick_at[ticks] = n_b;
        ticks++;
      end
      if (ticks == 1) begin
        if (bright_b) br_f++;
        if (!vSync_b) vs_f++;
      end
    end
    check_int("frame_tick_count", ticks, 4);
    if (ticks == 4) begin
      check_int("first_tick_edge", tick_at[0], 481);
      check_int("frame_period_clk", tick_at[1] - tick_at[0], 480);
      check_int("frame_period_clk_3", tick_at[3] - tick_at[2], 480);
      check_int("frame_count_seq", (fc_seq[0] << 6) | (fc_seq[1] << 4) | (fc_seq[2] << 2) | fc_seq[3],
                (1 << 6) | (2 << 4) | (3 << 2) | 0);
    end
    check_int("bright_clk_per_frame", br_f, 120);
    check_int("vsync_low_clk_per_frame", vs_f, 80);

    // Reset for a single clk mid-frame at (12,3).
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(posedge clk);
      #1;
      found = (hCount_b == 10'd12) && (vCount_b == 10'd3);
    end
    check_int("reach_mid_frame", found, 1);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    check("mid_frame_reset", obs_b(), mk(0, 0, 0, 0, 0, 0));
    repeat (20) @(posedge clk);
    #1;
    check("after_mid_reset", obs_b(), model_b(20));

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
